// File: rtl/code_checker.sv
// Keypad code checker: collects 8 digits, compares them with the stored code, then times OPEN or LOCKOUT.
// All outputs registered; a single shared down-counter times both timed states.
module code_checker #(
   parameter int MAX_TRIES      = 3,
   parameter int UNLOCK_CYCLES  = 500,
   parameter int LOCKOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       key_clear,
   input  logic [3:0] digit1_data,
   input  logic [3:0] digit2_data,
   input  logic [3:0] digit3_data,
   input  logic [3:0] digit4_data,
   input  logic [3:0] digit5_data,
   input  logic [3:0] digit6_data,
   input  logic [3:0] digit7_data,
   input  logic [3:0] digit8_data,
   output logic [3:0] entry_count,
   output logic       unlocked,
   output logic       error,
   output logic       locked_out,
   output logic [3:0] fail_count
);
   localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [TW-1:0] T_ONE       = TW'(1);
   localparam logic [3:0]    MAX_T       = 4'(MAX_TRIES);

   typedef enum logic [1:0] {ENTER, CHECK, OPEN, LOCKOUT} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [3:0]      fail_q, fail_d;
   logic            unl_q, unl_d;
   logic            err_q, err_d;
   logic            lock_q, lock_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [3:0]      digits_q [8];
   logic [3:0]      digits_d [8];
   logic [3:0]      code [8];
   logic            match;
   logic [3:0]      fail_inc;

   assign code[0] = digit1_data;
   assign code[1] = digit2_data;
   assign code[2] = digit3_data;
   assign code[3] = digit4_data;
   assign code[4] = digit5_data;
   assign code[5] = digit6_data;
   assign code[6] = digit7_data;
   assign code[7] = digit8_data;

   always_comb begin
      match = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (digits_q[i] != code[i]) match = 1'b0;
      end
      fail_inc = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      fail_d   = fail_q;
      unl_d    = unl_q;
      err_d    = 1'b0;
      lock_d   = lock_q;
      timer_d  = timer_q;
      digits_d = digits_q;
      unique case (state_q)
         ENTER: begin
            // clear has priority over a digit strobed in the same cycle
            if (key_clear) begin
               cnt_d = 4'd0;
            end else if (key_valid && key_digit <= 4'd9) begin
               digits_d[cnt_q[2:0]] = key_digit;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd7) state_d = CHECK;
            end
         end
         CHECK: begin
            cnt_d = 4'd0;
            if (match) begin
               state_d = OPEN;
               fail_d  = 4'd0;
               unl_d   = 1'b1;
               timer_d = UNLOCK_LOAD;
            end else begin
               err_d  = 1'b1;
               fail_d = fail_inc;
               if (fail_inc >= MAX_T) begin
                  state_d = LOCKOUT;
                  lock_d  = 1'b1;
                  timer_d = LOCK_LOAD;
               end else begin
                  state_d = ENTER;
               end
            end
         end
         OPEN: begin
            if (timer_q == '0) begin
               state_d = ENTER;
               unl_d   = 1'b0;
            end else begin
               timer_d = timer_q - T_ONE;
            end
         end
         LOCKOUT: begin
            if (timer_q == '0) begin
               state_d = ENTER;
               lock_d  = 1'b0;
               fail_d  = 4'd0;
            end else begin
               timer_d = timer_q - T_ONE;
            end
         end
         default: state_d = ENTER;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ENTER;
         cnt_q   <= 4'd0;
         fail_q  <= 4'd0;
         unl_q   <= 1'b0;
         err_q   <= 1'b0;
         lock_q  <= 1'b0;
         timer_q <= '0;
         for (int i = 0; i < 8; i++) digits_q[i] <= 4'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         fail_q   <= fail_d;
         unl_q    <= unl_d;
         err_q    <= err_d;
         lock_q   <= lock_d;
         timer_q  <= timer_d;
         digits_q <= digits_d;
      end
   end

   assign entry_count = cnt_q;
   assign fail_count  = fail_q;
   assign unlocked    = unl_q;
   assign error       = err_q;
   assign locked_out  = lock_q;
endmodule

// File: tb/tb_code_checker.sv
// Bench for code_checker: directed scenarios plus random keys against a time-window reference model.
module tb_code_checker;
   localparam int MAX_TRIES = 3;
   localparam int UNLOCK    = 500;
   localparam int LOCKOUT   = 1000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_valid = 1'b0;
   logic       key_clear = 1'b0;
   logic [3:0] key_digit = 4'd0;
   logic [3:0] code [8];
   logic [3:0] entry_count, fail_count;
   logic       unlocked, error, locked_out;

   code_checker #(.MAX_TRIES(MAX_TRIES), .UNLOCK_CYCLES(UNLOCK), .LOCKOUT_CYCLES(LOCKOUT)) dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit), .key_clear(key_clear),
      .digit1_data(code[0]), .digit2_data(code[1]), .digit3_data(code[2]), .digit4_data(code[3]),
      .digit5_data(code[4]), .digit6_data(code[5]), .digit7_data(code[6]), .digit8_data(code[7]),
      .entry_count(entry_count), .unlocked(unlocked), .error(error),
      .locked_out(locked_out), .fail_count(fail_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int errs  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d (time %0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: entered digits in a queue, OPEN/LOCKOUT as absolute cycle windows.
   int         t = 0;
   logic [3:0] ent [$];
   int         m_fails = 0;
   int         open_end = 0;
   int         lock_end = 0;
   bit         lock_pend = 0;
   bit         m_chk = 0;
   bit         m_err = 0;

   task automatic model_update();
      int tn;
      bit busy;
      bit same;
      tn = t + 1;
      if (!rst_n) begin
         ent.delete();
         m_fails = 0; open_end = 0; lock_end = 0; lock_pend = 0; m_chk = 0; m_err = 0;
         t = tn;
         return;
      end
      busy  = (t < open_end) || (t < lock_end);
      m_err = 0;
      if (lock_pend && tn == lock_end) begin
         m_fails   = 0;
         lock_pend = 0;
      end
      if (m_chk) begin
         m_chk = 0;
         same = 1;
         for (int i = 0; i < 8; i++) if (ent[i] != code[i]) same = 0;
         ent.delete();
         if (same) begin
            m_fails  = 0;
            open_end = tn + UNLOCK;
         end else begin
            m_err   = 1;
            m_fails = (m_fails >= 15) ? 15 : m_fails + 1;
            if (m_fails >= MAX_TRIES) begin
               lock_end  = tn + LOCKOUT;
               lock_pend = 1;
            end
         end
      end else if (!busy) begin
         if (key_clear) ent.delete();
         else if (key_valid && key_digit <= 4'd9) begin
            ent.push_back(key_digit);
            if (ent.size() == 8) m_chk = 1;
         end
      end
      t = tn;
   endtask

   task automatic compare_all();
      check("entry_count", 32'(entry_count), 32'(ent.size()));
      check("unlocked",    32'(unlocked),    32'(t < open_end));
      check("locked_out",  32'(locked_out),  32'(t < lock_end));
      check("error",       32'(error),       32'(m_err));
      check("fail_count",  32'(fail_count),  32'(m_fails));
   endtask

   task automatic step(input logic v, input logic [3:0] d, input logic c);
      key_valid = v; key_digit = d; key_clear = c;
      @(posedge clk);
      #1;
      model_update();
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0);
   endtask

   task automatic enter_word(input logic [31:0] w);
      for (int i = 0; i < 8; i++) step(1'b1, w[31-4*i -: 4], 1'b0);
   endtask

   function automatic logic [31:0] code_word();
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 8; i++) w[31-4*i -: 4] = code[i];
      return w;
   endfunction

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      check("rst_entry",    32'(entry_count), 32'd0);
      check("rst_unlocked", 32'(unlocked),    32'd0);
      check("rst_locked",   32'(locked_out),  32'd0);
      check("rst_error",    32'(error),       32'd0);
      check("rst_fails",    32'(fail_count),  32'd0);
      step(1'b0, 4'd0, 1'b0);
      rst_n = 1'b1;
   endtask

   int cnt;

   initial begin
      for (int i = 0; i < 8; i++) code[i] = 4'(i + 1);
      step(1'b0, 4'd0, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      rst_n = 1'b1;
      idle(2);

      // correct code -> OPEN for exactly UNLOCK cycles
      enter_word(32'h12345678);
      cnt = 0;
      for (int i = 0; i < UNLOCK + 4; i++) begin
         step(1'b0, 4'd0, 1'b0);
         if (unlocked) cnt++;
      end
      check("open_len", cnt, UNLOCK);

      // three mismatches -> lockout for exactly LOCKOUT cycles
      for (int k = 0; k < 3; k++) begin
         enter_word(32'h12345679);
         step(1'b0, 4'd0, 1'b0);
         check("err_fail_count", 32'(fail_count), 32'(k + 1));
      end
      cnt = 0;
      for (int i = 0; i < LOCKOUT + 4; i++) begin
         step(1'b0, 4'd0, 1'b0);
         if (locked_out) cnt++;
      end
      check("lock_len", cnt, LOCKOUT - 1);
      check("lock_fails_cleared", 32'(fail_count), 32'd0);

      // illegal digit ignored, keys during OPEN ignored
      step(1'b1, 4'd12, 1'b0);
      check("illegal_digit", 32'(entry_count), 32'd0);
      enter_word(32'h12345678);
      for (int i = 0; i < UNLOCK + 3; i++)
         step(1'b1, 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));

      // clear wins over simultaneous digit, then full code from digit 1
      step(1'b0, 4'd0, 1'b0);
      step(1'b1, 4'd1, 1'b0);
      step(1'b1, 4'd2, 1'b0);
      step(1'b1, 4'd3, 1'b0);
      step(1'b1, 4'd5, 1'b1);
      check("clear_wins", 32'(entry_count), 32'd0);
      enter_word(32'h12345678);
      step(1'b0, 4'd0, 1'b0);
      check("open_after_clear", 32'(unlocked), 32'd1);
      idle(UNLOCK + 2);

      // reset during lockout, then keys accepted from digit 1
      for (int k = 0; k < 3; k++) begin
         enter_word(32'h87654321);
         step(1'b0, 4'd0, 1'b0);
      end
      idle(299);
      check("lock_before_reset", 32'(locked_out), 32'd1);
      pulse_reset();
      enter_word(32'h12345678);
      step(1'b0, 4'd0, 1'b0);
      check("open_after_reset", 32'(unlocked), 32'd1);
      idle(UNLOCK + 2);

      // two failures, success clears count, one later failure does not lock
      enter_word(32'h00000000);
      step(1'b0, 4'd0, 1'b0);
      enter_word(32'h99999999);
      step(1'b0, 4'd0, 1'b0);
      check("two_fails", 32'(fail_count), 32'd2);
      enter_word(32'h12345678);
      step(1'b0, 4'd0, 1'b0);
      check("success_clears", 32'(fail_count), 32'd0);
      idle(UNLOCK + 2);
      enter_word(32'h12345670);
      step(1'b0, 4'd0, 1'b0);
      check("single_fail", 32'(fail_count), 32'd1);
      idle(3);
      check("no_lockout", 32'(locked_out), 32'd0);

      // randomized traffic
      for (int n = 0; n < 5000; n++) begin
         int r;
         r = $urandom_range(0, 999);
         if (r < 5) pulse_reset();
         else if (r < 40) enter_word(code_word());
         else if (r < 45) begin
            for (int i = 0; i < 8; i++) code[i] = 4'($urandom_range(0, 9));
            step(1'b0, 4'd0, 1'b0);
         end else
            step(1'($urandom_range(0, 9) < 6), 4'($urandom_range(0, 11)),
                 1'($urandom_range(0, 99) < 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end
endmodule
